// File: rtl/line_fifo_arbiter.sv
// Two-writer / two-reader arbiter in front of an external line FIFO.
// Round-robin write grant, fixed-priority read grant, and a flush mode that drains the FIFO.
module line_fifo_arbiter #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              p_wr_valid,
  input  logic [DATA_W-1:0] p_wr_data,
  output logic              p_wr_ready,
  input  logic              s_wr_valid,
  input  logic [DATA_W-1:0] s_wr_data,
  output logic              s_wr_ready,
  input  logic              p_rd_req,
  input  logic              s_rd_req,
  output logic              rd_valid,
  output logic              rd_owner,
  output logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] fifo_din,
  output logic              fifo_wr_en,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic              flush,
  output logic              flush_done,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t state_q, state_d;
  logic   rr_pref_s;
  logic   wr_ok, rd_ok, grant_p, grant_s, wr_xfer;
  logic   rd_grant_p, rd_grant_s, rd_grant, drain;
  logic   vld_p1, owner_p1;

  // Occupancy update, clamped to [0, DEPTH].
  function automatic logic [CNT_W-1:0] next_count(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic dec);
    if (inc && !dec && cur != DEPTH_C) return cur + 1'b1;
    if (dec && !inc && cur != '0)      return cur - 1'b1;
    return cur;
  endfunction

  // Stage p0: combinational grant and FIFO strobes; rst masks every strobe
  always_comb begin
    wr_ok      = !rst && (state_q == IDLE) && (count < DEPTH_C) && !fifo_full;
    rd_ok      = !rst && (state_q == IDLE) && (count != '0) && !fifo_empty;
    grant_p    = p_wr_valid && (!s_wr_valid || !rr_pref_s);
    grant_s    = s_wr_valid && !grant_p;
    p_wr_ready = wr_ok && grant_p;
    s_wr_ready = wr_ok && grant_s;
    wr_xfer    = p_wr_ready || s_wr_ready;
    fifo_wr_en = wr_xfer;
    fifo_din   = grant_s ? s_wr_data : p_wr_data;
    rd_grant_p = rd_ok && p_rd_req;
    rd_grant_s = rd_ok && !p_rd_req && s_rd_req;
    rd_grant   = rd_grant_p || rd_grant_s;
    drain      = !rst && (state_q == FLUSH) && (count != '0);
    fifo_rd_en = rd_grant || drain;
    flush_done = !rst && (state_q == FLUSH) && (count == '0);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (flush) state_d = FLUSH;
      FLUSH:   if (count == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stage p1: state, occupancy and read-return qualifiers
  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q   <= IDLE;
      count     <= '0;
      rr_pref_s <= 1'b0;
      vld_p1    <= 1'b0;
      owner_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= next_count(count, wr_xfer, fifo_rd_en);
      if (wr_xfer) rr_pref_s <= p_wr_ready;
      vld_p1 <= rd_grant;
      if (rd_grant) owner_p1 <= rd_grant_s;
    end
  end

  assign rd_valid = vld_p1;
  assign rd_owner = owner_p1;
  assign rd_data  = fifo_dout;

endmodule

// File: tb/tb_line_fifo_arbiter.sv
// Self-checking bench for line_fifo_arbiter: a queue-backed FIFO model plus a word-level
// reference of grants, occupancy and flush behaviour, driven by directed and random stimulus.
module tb_line_fifo_arbiter;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk_100mhz = 1'b0;
  logic              rst = 1'b1;
  logic              p_wr_valid = 1'b0, s_wr_valid = 1'b0;
  logic [DATA_W-1:0] p_wr_data = '0, s_wr_data = '0;
  logic              p_wr_ready, s_wr_ready;
  logic              p_rd_req = 1'b0, s_rd_req = 1'b0;
  logic              rd_valid, rd_owner;
  logic [DATA_W-1:0] rd_data, fifo_din;
  logic              fifo_wr_en, fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout = '0;
  logic              fifo_full = 1'b0, fifo_empty = 1'b1;
  logic              flush = 1'b0, flush_done;
  logic [CNT_W-1:0]  count;

  always #5 clk_100mhz = ~clk_100mhz;

  line_fifo_arbiter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_100mhz(clk_100mhz), .rst(rst),
    .p_wr_valid(p_wr_valid), .p_wr_data(p_wr_data), .p_wr_ready(p_wr_ready),
    .s_wr_valid(s_wr_valid), .s_wr_data(s_wr_data), .s_wr_ready(s_wr_ready),
    .p_rd_req(p_rd_req), .s_rd_req(s_rd_req),
    .rd_valid(rd_valid), .rd_owner(rd_owner), .rd_data(rd_data),
    .fifo_din(fifo_din), .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .flush(flush), .flush_done(flush_done), .count(count)
  );

  // Attached FIFO: standard read, data one cycle after the read strobe
  logic [DATA_W-1:0] fq[$];
  always @(posedge clk_100mhz) begin
    if (rst) begin
      fq.delete();
    end else begin
      if (fifo_rd_en && fq.size() > 0) fifo_dout <= fq.pop_front();
      if (fifo_wr_en) fq.push_back(fifo_din);
    end
    fifo_empty <= (fq.size() == 0);
    fifo_full  <= (fq.size() >= DEPTH);
  end

  int n_checks = 0, n_errors = 0;

  // Reference state: the words the FIFO should hold, flush mode, last write winner
  logic [DATA_W-1:0] m_q[$];
  bit                m_flush;
  int                m_last_wr;
  bit                e_rv, e_own;
  logic [DATA_W-1:0] e_rd;

  bit obs_pr, obs_sr, obs_rd, obs_fd;
  int n_wr_en, n_rd_en, n_rv, n_fd, n_sr, n_ready;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_tallies();
    n_wr_en = 0; n_rd_en = 0; n_rv = 0; n_fd = 0; n_sr = 0; n_ready = 0;
  endtask

  // Called on a falling edge; returns on the next falling edge.
  task automatic cycle(input bit pv, input logic [DATA_W-1:0] pd, input bit sv,
                       input logic [DATA_W-1:0] sd, input bit prr, input bit srr, input bit fl);
    bit wr_ok, rd_ok, tie_p, gp, gs, rp, rs, drain, done;
    logic [DATA_W-1:0] dump;
    p_wr_valid = pv; p_wr_data = pd; s_wr_valid = sv; s_wr_data = sd;
    p_rd_req = prr; s_rd_req = srr; flush = fl;
    #1;
    wr_ok = !m_flush && (m_q.size() < DEPTH) && !fifo_full;
    tie_p = (m_last_wr != 0);
    gp    = wr_ok && pv && (!sv || tie_p);
    gs    = wr_ok && sv && (!pv || !tie_p);
    rd_ok = !m_flush && (m_q.size() > 0) && !fifo_empty;
    rp    = rd_ok && prr;
    rs    = rd_ok && !prr && srr;
    drain = m_flush && (m_q.size() > 0);
    done  = m_flush && (m_q.size() == 0);
    obs_pr = p_wr_ready; obs_sr = s_wr_ready; obs_rd = fifo_rd_en; obs_fd = flush_done;
    chk("p_wr_ready", 32'(p_wr_ready), 32'(gp));
    chk("s_wr_ready", 32'(s_wr_ready), 32'(gs));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(gp || gs));
    if (gp || gs) chk("fifo_din", 32'(fifo_din), 32'(gp ? pd : sd));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(rp || rs || drain));
    chk("flush_done", 32'(flush_done), 32'(done));
    n_wr_en += int'(fifo_wr_en); n_rd_en += int'(fifo_rd_en); n_fd += int'(flush_done);
    n_sr += int'(s_wr_ready); n_ready += int'(p_wr_ready || s_wr_ready);
    e_rv = rp || rs;
    if (e_rv) begin
      e_own = rs;
      e_rd  = m_q.pop_front();
    end else if (drain) begin
      dump = m_q.pop_front();
    end
    if (gp) begin m_q.push_back(pd); m_last_wr = 0; end
    if (gs) begin m_q.push_back(sd); m_last_wr = 1; end
    if (m_flush) begin
      if (done) m_flush = 1'b0;
    end else if (fl) begin
      m_flush = 1'b1;
    end
    @(posedge clk_100mhz);
    #1;
    chk("rd_valid", 32'(rd_valid), 32'(e_rv));
    chk("rd_owner", 32'(rd_owner), 32'(e_own));
    if (e_rv) chk("rd_data", 32'(rd_data), 32'(e_rd));
    chk("count", 32'(count), 32'(m_q.size()));
    n_rv += int'(rd_valid);
    @(negedge clk_100mhz);
  endtask

  task automatic idle_cycle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic p_write(input logic [DATA_W-1:0] d);
    cycle(1'b1, d, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset with every request active: no strobe or completion may leak out.
  task automatic do_reset(input int cycles);
    rst = 1'b1;
    p_wr_valid = 1'b1; s_wr_valid = 1'b1; p_rd_req = 1'b1; s_rd_req = 1'b1; flush = 1'b1;
    repeat (cycles) begin
      #1;
      chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
      chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
      chk("rst_flush_done", 32'(flush_done), 32'd0);
      n_fd += int'(flush_done);
      @(posedge clk_100mhz);
      @(negedge clk_100mhz);
    end
    rst = 1'b0;
    p_wr_valid = 1'b0; s_wr_valid = 1'b0; p_rd_req = 1'b0; s_rd_req = 1'b0; flush = 1'b0;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_rd_owner", 32'(rd_owner), 32'd0);
    chk("rst_flush_done_after", 32'(flush_done), 32'd0);
    chk("rst_rd_en_after", 32'(fifo_rd_en), 32'd0);
    m_q.delete(); m_flush = 1'b0; m_last_wr = -1; e_rv = 1'b0; e_own = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] seq;
    int k;
    bit got_done;

    do_reset(2);

    // Parser alone writes five words
    clear_tallies();
    for (int i = 1; i <= 5; i++) p_write(16'(i));
    chk("p_only_wr_pulses", 32'(n_wr_en), 32'd5);
    chk("p_only_count", 32'(count), 32'd5);
    chk("p_only_s_ready", 32'(n_sr), 32'd0);

    // Both writers contend: alternating grants starting with parser
    do_reset(1);
    seq = '0;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 16'hAAAA, 1'b1, 16'h5555, 1'b0, 1'b0, 1'b0);
      seq = {seq[2:0], obs_sr};
    end
    chk("rr_grant_seq", 32'(seq), 32'b0101);
    chk("rr_count", 32'(count), 32'd4);

    // Simultaneous read requests at count 3: parser wins
    do_reset(1);
    for (int i = 1; i <= 3; i++) p_write(16'(i));
    cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 1'b0);
    chk("rd_prio_valid", 32'(rd_valid), 32'd1);
    chk("rd_prio_owner", 32'(rd_owner), 32'd0);
    chk("rd_prio_data", 32'(rd_data), 32'h0001);
    chk("rd_prio_count", 32'(count), 32'd2);
    // Back-to-back solver reads
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    chk("b2b_owner", 32'(rd_owner), 32'd1);
    chk("b2b_data", 32'(rd_data), 32'h0003);
    chk("b2b_count", 32'(count), 32'd0);

    // Empty: write wins, no fall-through; then fill to DEPTH
    do_reset(1);
    cycle(1'b1, 16'h1234, 1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("empty_rw_rd_valid", 32'(rd_valid), 32'd0);
    chk("empty_rw_count", 32'(count), 32'd1);
    for (int i = 1; i < DEPTH; i++)
      cycle(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
    chk("full_count", 32'(count), 32'(DEPTH));
    cycle(1'b1, 16'h0F0F, 1'b1, 16'hF0F0, 1'b0, 1'b1, 1'b0);
    chk("full_p_ready", 32'(obs_pr), 32'd0);
    chk("full_s_ready", 32'(obs_sr), 32'd0);
    chk("full_rd_grant", 32'(obs_rd), 32'd1);
    chk("full_after_count", 32'(count), 32'(DEPTH - 1));

    // Flush of seven words with writers and readers pushing throughout
    do_reset(1);
    for (int i = 0; i < 7; i++) p_write(16'($urandom));
    clear_tallies();
    idle_cycle();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    clear_tallies();
    got_done = 1'b0; k = 0;
    while (!got_done && k < 30) begin
      cycle(1'b1, 16'($urandom), 1'b1, 16'($urandom), 1'b1, 1'b1, 1'b1);
      k++;
      got_done = obs_fd;
    end
    if (!got_done) chk("flush_done_timeout", 32'd0, 32'd1);
    chk("flush_cycles", 32'(k), 32'd8);
    chk("flush_rd_pulses", 32'(n_rd_en), 32'd7);
    chk("flush_rd_valid", 32'(n_rv), 32'd0);
    chk("flush_wr_blocked", 32'(n_ready), 32'd0);
    chk("flush_done_pulses", 32'(n_fd), 32'd1);
    cycle(1'b1, 16'h7777, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("flush_back_idle", 32'(obs_pr), 32'd1);

    // Flush with an empty FIFO completes in two cycles
    do_reset(1);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("empty_flush_done", 32'(obs_fd), 32'd1);

    // Reset two cycles into a flush aborts it
    do_reset(1);
    for (int i = 0; i < 5; i++) p_write(16'($urandom));
    clear_tallies();
    cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    idle_cycle();
    do_reset(1);
    for (int i = 0; i < 3; i++) idle_cycle();
    chk("abort_flush_done", 32'(n_fd), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    p_write(16'h4242);
    chk("abort_idle_write", 32'(obs_pr), 32'd1);

    // Randomized traffic alternating write-heavy and read-heavy phases
    for (int i = 0; i < 4000; i++) begin
      bit wh;
      wh = ((i / 300) % 2) == 0;
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1);
      end else begin
        cycle($urandom_range(0, 99) < (wh ? 70 : 25), 16'($urandom),
              $urandom_range(0, 99) < (wh ? 70 : 25), 16'($urandom),
              $urandom_range(0, 99) < (wh ? 20 : 60),
              $urandom_range(0, 99) < (wh ? 20 : 60),
              $urandom_range(0, 79) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/line_fifo_arbiter.md
LINE_FIFO_ARBITER -- requirements
Module: line_fifo_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, 16, width of one encoded line option word.
REQ-002 SHALL have parameter DEPTH, 512, capacity in words of the attached line FIFO.
REQ-003 SHALL have parameter CNT_W, $clog2(DEPTH+1), width of the occupancy count.
REQ-004 SHALL have clk_100mhz  input  1  rising-edge clock for all state.
REQ-005 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have p_wr_valid / p_wr_data / p_wr_ready  in / in / out  1 / DATA_W / 1  parser write channel.
REQ-007 SHALL have s_wr_valid / s_wr_data / s_wr_ready  in / in / out  1 / DATA_W / 1  solver write-back channel.
REQ-008 SHALL have p_rd_req / s_rd_req  input  1 each  parser and solver read requests, level-sensitive.
REQ-009 SHALL have rd_valid / rd_owner / rd_data  out / out / out  1 / 1 / DATA_W  returned word; owner 0 = parser, 1 = solver.
REQ-010 SHALL have fifo_din / fifo_wr_en / fifo_rd_en  out / out / out  DATA_W / 1 / 1  FIFO write and read strobes.
REQ-011 SHALL have fifo_dout / fifo_full / fifo_empty  in / in / in  DATA_W / 1 / 1  FIFO data and flags; standard read, data valid 1 cycle after fifo_rd_en.
REQ-012 SHALL have flush / flush_done  in / out  1 / 1  drain request pulse; completion pulse.
REQ-013 SHALL have count  output  CNT_W  registered words held in FIFO.

Function
REQ-014 SHALL run FSM states IDLE (arbitrate) and FLUSH (drain).
REQ-015 Write accept condition: state IDLE, count < DEPTH, fifo_full = 0; then exactly one writer granted per cycle.
REQ-016 Write ready is combinational: only the granted writer sees ready = 1 when accept condition holds; a writer with valid = 0 is never granted.
REQ-017 One writer valid: that writer granted. Both valid: round-robin; grant the writer not granted at last accepted write; after reset parser wins first tie.
REQ-018 Transfer occurs when valid & ready; fifo_wr_en = 1 and fifo_din = granted data in that same cycle; round-robin pointer updates only on a transfer.
REQ-019 Read grant condition: state IDLE, count > 0, fifo_empty = 0; fixed priority, parser over solver; fifo_rd_en = 1 in the grant cycle.
REQ-020 rd_valid = 1 exactly one cycle after a granted read, rd_owner = granted requester, rd_data = fifo_dout; rd_valid = 0 otherwise, rd_data don't-care.
REQ-021 Requester holding rd_req high SHALL receive one word per cycle while grant condition holds (back-to-back reads).
REQ-022 count: +1 on write only, -1 on read only, unchanged on simultaneous read and write; never exceeds DEPTH nor goes below 0.
REQ-023 count = 0 with write and read request same cycle: write accepted, read not granted (no fall-through).
REQ-024 count = DEPTH with write and read same cycle: read granted, write not ready.
REQ-025 flush = 1 in IDLE: enter FLUSH next cycle; any read or write in the flush cycle itself completes normally.
REQ-026 In FLUSH: both wr_ready = 0, rd_req ignored, fifo_rd_en = 1 each cycle while count > 0, rd_valid stays 0, drained data discarded.
REQ-027 In FLUSH with count = 0: flush_done = 1 for one cycle, return to IDLE next cycle; flush with empty FIFO completes in 2 cycles.
REQ-028 flush asserted while already in FLUSH SHALL be ignored.

Reset
REQ-029 On rst: state IDLE, count = 0, rd_valid = 0, rd_owner = 0, flush_done = 0, fifo_wr_en = 0, fifo_rd_en = 0, round-robin pointer = parser-first.
REQ-030 rst mid-FLUSH or mid-read SHALL abort immediately; no rd_valid or flush_done emitted for the aborted operation; FIFO reset is external.
REQ-031 All outputs SHALL be valid in the first cycle after rst deasserts.

Verification
REQ-032 Parser writes 0x0001..0x0005 alone -> 5 fifo_wr_en pulses, count = 5, s_wr_ready = 0 throughout.
REQ-033 Both writers valid 4 cycles (P=0xAAAA, S=0x5555) -> grants P,S,P,S; count = 4.
REQ-034 count = 3, p_rd_req and s_rd_req high 1 cycle -> parser granted, next cycle rd_valid = 1, rd_owner = 0, count = 2.
REQ-035 count = 0, write and read same cycle -> write accepted, no rd_valid next cycle, count = 1; fill to DEPTH -> both wr_ready = 0.
REQ-036 count = 7, flush pulse -> 7 fifo_rd_en pulses, no rd_valid, flush_done one cycle after count hits 0, writers blocked throughout.
REQ-037 rst asserted 2 cycles into FLUSH -> count = 0, IDLE, flush_done never asserted.
